// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use bubble insertion,
//            external hold and wrong-path flush.
// Config   : define ID_EX_HAZARD_DETECT_EN to enable load-use detection.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_dst,
  input  logic              jump,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic [1:0]        alu_op,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic              ex_reg_dst,
  output logic              ex_jump,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd
);

  localparam int CTRL_W = 11;

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_d,     ctrl_q;
  logic [DATA_W-1:0] pc_plus4_d, pc_plus4_q;
  logic [DATA_W-1:0] rd1_d,      rd1_q;
  logic [DATA_W-1:0] rd2_d,      rd2_q;
  logic [DATA_W-1:0] imm_d,      imm_q;
  logic [REG_W-1:0]  rs_d,       rs_q;
  logic [REG_W-1:0]  rt_d,       rt_q;
  logic [REG_W-1:0]  rd_d,       rd_q;
  logic              haz;
  logic              load_data;

  // Control group packed with ex_valid in the MSB so a bubble is a single clear.
  assign ctrl_in = {id_valid, alu_op, reg_dst, jump, branch, mem_read,
                    mem_to_reg, mem_write, alu_src, reg_write};

  assign {ex_valid, ex_alu_op, ex_reg_dst, ex_jump, ex_branch, ex_mem_read,
          ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write} = ctrl_q;

  assign ex_pc_plus4 = pc_plus4_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;

`ifdef ID_EX_HAZARD_DETECT_EN
  logic rs_hit;
  logic rt_hit;

  // A jump has no rs source; rt is only a source for R-type, stores and branches.
  always_comb begin
    rs_hit = ~jump & (id_rs == rt_q);
    rt_hit = (reg_dst | mem_write | branch) & (id_rt == rt_q);
    haz    = ex_valid & ex_mem_read & (rt_q != '0) & id_valid & (rs_hit | rt_hit);
  end
`else
  assign haz = 1'b0;
`endif

  // Not gated by hold: upstream is already frozen whenever hold is high.
  assign stall = haz & ~flush;

  always_comb begin
    ctrl_d    = ctrl_q;
    load_data = 1'b0;
    if (flush) begin
      ctrl_d    = '0;
      load_data = 1'b1;
    end else if (hold) begin
      ctrl_d    = ctrl_q;
    end else if (haz) begin
      ctrl_d    = '0;
      load_data = 1'b1;
    end else begin
      ctrl_d    = id_valid ? ctrl_in : '0;
      load_data = 1'b1;
    end
  end

  always_comb begin
    pc_plus4_d = pc_plus4_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    if (load_data) begin
      pc_plus4_d = id_pc_plus4;
      rd1_d      = id_rd1;
      rd2_d      = id_rd2;
      imm_d      = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rd_d       = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      pc_plus4_q <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_plus4_q <= pc_plus4_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic        reg_dst;
    logic        jump;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  flush;
  logic  hold;
  logic  stall;
  slot_t in_s;
  slot_t obs;
  slot_t m;
  logic  m_known = 1'b0;
  logic  last_stall;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_dst(in_s.reg_dst), .jump(in_s.jump), .branch(in_s.branch),
    .mem_read(in_s.mem_read), .mem_to_reg(in_s.mem_to_reg),
    .mem_write(in_s.mem_write), .alu_src(in_s.alu_src),
    .reg_write(in_s.reg_write), .alu_op(in_s.alu_op), .id_valid(in_s.valid),
    .id_pc_plus4(in_s.pc), .id_rd1(in_s.rd1), .id_rd2(in_s.rd2),
    .id_imm(in_s.imm), .id_rs(in_s.rs), .id_rt(in_s.rt), .id_rd(in_s.rd),
    .flush(flush), .hold(hold), .stall(stall),
    .ex_reg_dst(obs.reg_dst), .ex_jump(obs.jump), .ex_branch(obs.branch),
    .ex_mem_read(obs.mem_read), .ex_mem_to_reg(obs.mem_to_reg),
    .ex_mem_write(obs.mem_write), .ex_alu_src(obs.alu_src),
    .ex_reg_write(obs.reg_write), .ex_alu_op(obs.alu_op), .ex_valid(obs.valid),
    .ex_pc_plus4(obs.pc), .ex_rd1(obs.rd1), .ex_rd2(obs.rd2), .ex_imm(obs.imm),
    .ex_rs(obs.rs), .ex_rt(obs.rt), .ex_rd(obs.rd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [10:0] ctrl_of(input slot_t s);
    return {s.valid, s.alu_op, s.reg_dst, s.jump, s.branch, s.mem_read,
            s.mem_to_reg, s.mem_write, s.alu_src, s.reg_write};
  endfunction

  function automatic slot_t bubble(input slot_t s);
    slot_t r;
    r            = s;
    r.valid      = 1'b0;
    r.alu_op     = 2'b00;
    r.reg_dst    = 1'b0;
    r.jump       = 1'b0;
    r.branch     = 1'b0;
    r.mem_read   = 1'b0;
    r.mem_to_reg = 1'b0;
    r.mem_write  = 1'b0;
    r.alu_src    = 1'b0;
    r.reg_write  = 1'b0;
    return r;
  endfunction

  // Load in EX whose destination is a source register of the valid ID instruction.
  function automatic logic load_use(input slot_t ex, input slot_t id);
`ifdef ID_EX_HAZARD_DETECT_EN
    logic uses_rs, uses_rt;
    uses_rs = !id.jump && id.rs == ex.rt;
    uses_rt = (id.reg_dst || id.mem_write || id.branch) && id.rt == ex.rt;
    return ex.valid && ex.mem_read && ex.rt != 5'd0 && id.valid && (uses_rs || uses_rt);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    logic h;
    @(negedge clk);
    h          = m_known && load_use(m, in_s);
    last_stall = stall;
    if (m_known) check("stall", 64'(stall), 64'(h && !flush));
    @(posedge clk);
    if (!rst_n)     begin m = '0; m_known = 1'b1; end
    else if (flush) m = bubble(in_s);
    else if (hold)  m = m;
    else if (h)     m = bubble(in_s);
    else            m = in_s.valid ? in_s : bubble(in_s);
    #1;
    if (m_known) begin
      check("ctrl", 64'(ctrl_of(obs)), 64'(ctrl_of(m)));
      check("pc",   64'(obs.pc),  64'(m.pc));
      check("rd1",  64'(obs.rd1), 64'(m.rd1));
      check("rd2",  64'(obs.rd2), 64'(m.rd2));
      check("imm",  64'(obs.imm), 64'(m.imm));
      check("regs", 64'({obs.rs, obs.rt, obs.rd}), 64'({m.rs, m.rt, m.rd}));
    end
  endtask

  task automatic rand_inputs();
    in_s.valid      = 1'($urandom_range(0, 3) != 0);
    in_s.alu_op     = 2'($urandom_range(0, 3));
    in_s.reg_dst    = 1'($urandom_range(0, 1));
    in_s.jump       = 1'($urandom_range(0, 3) == 0);
    in_s.branch     = 1'($urandom_range(0, 3) == 0);
    in_s.mem_read   = 1'($urandom_range(0, 1));
    in_s.mem_to_reg = 1'($urandom_range(0, 1));
    in_s.mem_write  = 1'($urandom_range(0, 3) == 0);
    in_s.alu_src    = 1'($urandom_range(0, 1));
    in_s.reg_write  = 1'($urandom_range(0, 1));
    in_s.pc         = $urandom;
    in_s.rd1        = $urandom;
    in_s.rd2        = $urandom;
    in_s.imm        = $urandom;
    in_s.rs         = 5'($urandom_range(0, 3));
    in_s.rt         = 5'($urandom_range(0, 3));
    in_s.rd         = 5'($urandom_range(0, 31));
  endtask

  task automatic set_lw(input logic [4:0] rt);
    in_s = '0; in_s.valid = 1'b1; in_s.mem_read = 1'b1; in_s.mem_to_reg = 1'b1;
    in_s.alu_src = 1'b1; in_s.reg_write = 1'b1; in_s.rs = 5'd1; in_s.rt = rt;
    in_s.imm = 32'h4; in_s.pc = 32'h100;
  endtask

  task automatic set_add(input logic [4:0] rs);
    in_s = '0; in_s.valid = 1'b1; in_s.reg_dst = 1'b1; in_s.reg_write = 1'b1;
    in_s.alu_op = 2'b10; in_s.rs = rs; in_s.rt = 5'd3; in_s.rd = 5'd10;
    in_s.pc = 32'h104; in_s.imm = 32'h5020;
  endtask

  initial begin
    // reset with every input high
    in_s = '1; flush = 1'b1; hold = 1'b1; rst_n = 1'b0;
    step(); step();
    check("rst_valid", 64'(obs.valid), 64'd0);
    check("rst_imm",   64'(obs.imm),   64'd0);
    rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
    step();
    check("rel_rd1", 64'(obs.rd1), 64'hffff_ffff);

    // R-type pass-through
    in_s = '0; in_s.valid = 1'b1; in_s.reg_dst = 1'b1; in_s.reg_write = 1'b1;
    in_s.alu_op = 2'b10; in_s.rd1 = 32'h11; in_s.rd2 = 32'h22; in_s.rd = 5'd8;
    step();
    check("pt_rd1",   64'(obs.rd1),    64'h11);
    check("pt_rd2",   64'(obs.rd2),    64'h22);
    check("pt_aluop", 64'(obs.alu_op), 64'd2);

    // load-use on r9
    set_lw(5'd9); step();
    set_add(5'd9); step();
`ifdef ID_EX_HAZARD_DETECT_EN
    check("lu_stall",  64'(last_stall), 64'd1);
    check("lu_bubble", 64'(obs.valid),  64'd0);
    step();
    check("lu_stall2", 64'(last_stall), 64'd0);
`else
    check("lu_nostall", 64'(last_stall), 64'd0);
`endif
    check("lu_addrd", 64'(obs.rd), 64'd10);
    check("lu_addv",  64'(obs.valid), 64'd1);

    // load to r0 never stalls
    set_lw(5'd0); step();
    set_add(5'd0); step();
    check("r0_stall", 64'(last_stall), 64'd0);
    check("r0_valid", 64'(obs.valid),  64'd1);

    // flush beats hold and hazard
    set_lw(5'd9); step();
    set_add(5'd9); in_s.imm = 32'h1234; flush = 1'b1; hold = 1'b1;
    step();
    check("fl_stall", 64'(last_stall), 64'd0);
    check("fl_ctrl",  64'(ctrl_of(obs)), 64'd0);
    check("fl_imm",   64'(obs.imm), 64'h1234);
    flush = 1'b0; hold = 1'b0;

    // hold for three edges while inputs change
    set_add(5'd2); step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); step();
      check("hold_rd", 64'(obs.rd), 64'd10);
    end
    hold = 1'b0; rand_inputs(); step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      flush = 1'($urandom_range(0, 9) == 0);
      hold  = 1'($urandom_range(0, 6) == 0);
      rst_n = 1'($urandom_range(0, 49) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
